uart_rx_fifo: RTL and testbench

- Parametrised successor to the current UART receiver core.
- Adds configurable oversampling, mid-bit qualified start detection, a separate parity state, framing error and break detection, and a receive FIFO with a valid/ready read port.
- The FIFO fill level drives the cts_n hardware flow-control output.
- Sits between the baud-tick generator / RX pad and the register/bus interface of the UART.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_rx_fifo.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   state_t     : receiver FSM states
//   data_bits_e : encoding of the data_bit_num frame-format field
//   rx_entry_t  : one receive FIFO entry {frame_err, parity_err, data}
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   typedef enum logic [1:0] {
      DBITS_5 = 2'b00,
      DBITS_6 = 2'b01,
      DBITS_7 = 2'b10,
      DBITS_8 = 2'b11
   } data_bits_e;

   typedef struct packed {
      logic       frame_err;
      logic       parity_err;
      logic [7:0] data;
   } rx_entry_t;

   localparam int RX_ENTRY_W = $bits(rx_entry_t);

   // Index of the last data bit: 5 bits -> 4 ... 8 bits -> 7, i.e. {1, enc}.
   function automatic logic [2:0] last_bit_idx(input data_bits_e db);
      return {1'b1, db};
   endfunction

   // 2-of-3 majority vote.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with show-ahead read (pop_data is the current head).
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle, so push+pop on full leaves the count unchanged.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write strobe and data
//   full               FIFO holds DEPTH entries
//   pop                read strobe (ignored when empty)
//   pop_data           head entry (undefined when empty)
//   empty              FIFO holds no entries
//   count              occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign empty    = (cnt == '0);
   assign full     = (cnt == FULL_CNT);
   assign count    = cnt;
   assign pop_data = mem[rd_ptr];
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver with oversampling, mid-bit qualified start detection, parity,
// framing-error and break detection, feeding a receive FIFO with a
// valid/ready read port and cts_n flow control derived from the fill level.
//
// Optional build macro UART_RX_MAJORITY_EN: every bit decision is the 2-of-3
// majority of three consecutive oversamples centred on mid-bit; otherwise a
// single mid-bit sample is used.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  oversample strobe, OVS per bit period
//   rx                    asynchronous serial input, idle high
//   data_bit_num          00=5, 01=6, 10=7, 11=8 data bits
//   stop_bit_num          0=1 stop bit, 1=2 stop bits
//   parity_en/parity_type parity present / 0=even, 1=odd
//   rts_n                 host receive enable (active low)
//   rd_valid/rd_ready     FIFO read handshake
//   rd_data               head data, right-justified
//   rd_parity_err         head entry parity error
//   rd_frame_err          head entry framing error
//   fifo_count            FIFO occupancy
//   overrun               pulse: complete frame dropped, FIFO full
//   break_det             pulse: break frame detected
//   cts_n                 registered flow-control output
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int OVS        = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CTS_MARGIN = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tick,
   input  logic                          rx,
   input  logic [1:0]                    data_bit_num,
   input  logic                          stop_bit_num,
   input  logic                          parity_en,
   input  logic                          parity_type,
   input  logic                          rts_n,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [7:0]                    rd_data,
   output logic                          rd_parity_err,
   output logic                          rd_frame_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          break_det,
   output logic                          cts_n
);

   localparam int TW = $clog2(OVS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Decision point inside the start bit. The tick counter restarts on every
   // state entry, so later bits are decided OVS ticks after the previous one.
`ifdef UART_RX_MAJORITY_EN
   localparam logic [TW-1:0] START_DEC = TW'(OVS/2);
`else
   localparam logic [TW-1:0] START_DEC = TW'(OVS/2 - 1);
`endif
   localparam logic [TW-1:0] BIT_DEC   = TW'(OVS - 1);
   localparam logic [CW-1:0] CTS_LEVEL = CW'(FIFO_DEPTH - CTS_MARGIN);

   logic          rx_sync_p0;
   logic          rx_sync_p1;
   logic          rx_prev_p2;

   state_t        state;
   logic [TW-1:0] tick_cnt;
   data_bits_e    cfg_data;
   logic          cfg_stop2;
   logic          cfg_pen;
   logic          cfg_ptype;
   logic [2:0]    bit_idx;
   logic          stop_second;
   logic          all_zero;
   logic          frame_done;

   logic          start_edge;
   logic          dec_pt;
   logic          bit_val;

   logic [7:0]    data_sh;
   logic          par_acc;
   logic          parity_err_r;
   logic          frame_err_r;

   rx_entry_t     push_entry;
   rx_entry_t     head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;

   // ---- stage p0/p1: rx synchroniser, p2: previous sample for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
         rx_prev_p2 <= 1'b1;
      end else begin
         rx_sync_p0 <= rx;
         rx_sync_p1 <= rx_sync_p0;
         rx_prev_p2 <= rx_sync_p1;
      end
   end

   assign start_edge = rx_prev_p2 & ~rx_sync_p1;
   assign dec_pt     = tick & (tick_cnt == ((state == START) ? START_DEC : BIT_DEC));

`ifdef UART_RX_MAJORITY_EN
   // The two oversamples preceding the decision tick.
   logic [1:0] smp_hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_hist <= 2'b11;
      end else if (tick) begin
         smp_hist <= {smp_hist[0], rx_sync_p1};
      end
   end

   assign bit_val = maj3(smp_hist[1], smp_hist[0], rx_sync_p1);
`else
   assign bit_val = rx_sync_p1;
`endif

   // ---- receiver FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         cfg_data    <= DBITS_5;
         cfg_stop2   <= 1'b0;
         cfg_pen     <= 1'b0;
         cfg_ptype   <= 1'b0;
         bit_idx     <= '0;
         stop_second <= 1'b0;
         all_zero    <= 1'b0;
         frame_done  <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         break_det  <= 1'b0;
         if (tick) tick_cnt <= tick_cnt + TW'(1);

         case (state)
            IDLE: begin
               if (start_edge) begin
                  state     <= START;
                  tick_cnt  <= '0;
                  cfg_data  <= data_bits_e'(data_bit_num);
                  cfg_stop2 <= stop_bit_num;
                  cfg_pen   <= parity_en;
                  cfg_ptype <= parity_type;
                  all_zero  <= 1'b1;
               end
            end

            START: begin
               if (dec_pt) begin
                  tick_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= bit_val ? IDLE : DATA;
               end
            end

            DATA: begin
               if (dec_pt) begin
                  tick_cnt <= '0;
                  if (bit_val) all_zero <= 1'b0;
                  if (bit_idx == last_bit_idx(cfg_data)) begin
                     stop_second <= 1'b0;
                     state       <= cfg_pen ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end

            PARITY: begin
               if (dec_pt) begin
                  tick_cnt    <= '0;
                  stop_second <= 1'b0;
                  if (bit_val) all_zero <= 1'b0;
                  state <= STOP;
               end
            end

            STOP: begin
               if (dec_pt) begin
                  tick_cnt <= '0;
                  // Break is judged on the first stop bit; the frame ends here.
                  if (!stop_second && all_zero && !bit_val) begin
                     break_det <= 1'b1;
                     state     <= IDLE;
                  end else if (cfg_stop2 && !stop_second) begin
                     stop_second <= 1'b1;
                  end else begin
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // ---- frame assembly; cleared at each start, so no reset needed
   always_ff @(posedge clk) begin
      if (state == IDLE && start_edge) begin
         data_sh      <= '0;
         par_acc      <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else if (dec_pt) begin
         case (state)
            DATA: begin
               data_sh[bit_idx] <= bit_val;
               par_acc          <= par_acc ^ bit_val;
            end
            PARITY:  parity_err_r <= par_acc ^ bit_val ^ cfg_ptype;
            STOP:    if (!bit_val) frame_err_r <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      push_entry            = '0;
      push_entry.frame_err  = frame_err_r;
      push_entry.parity_err = parity_err_r;
      push_entry.data       = data_sh;
   end

   assign pop = rd_valid & rd_ready;

   uart_sync_fifo #(
      .WIDTH (RX_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (frame_done),
      .push_data (push_entry),
      .full      (fifo_full),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Head fields are forced to 0 when empty so the read port never shows
   // stale or uninitialised storage.
   assign rd_valid      = ~fifo_empty;
   assign rd_data       = fifo_empty ? 8'h00 : head.data;
   assign rd_parity_err = ~fifo_empty & head.parity_err;
   assign rd_frame_err  = ~fifo_empty & head.frame_err;

   // ---- status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cts_n   <= 1'b1;
         overrun <= 1'b0;
      end else begin
         cts_n   <= rts_n | (fifo_count >= CTS_LEVEL);
         overrun <= frame_done & fifo_full & ~pop;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam int OVS    = 16;
   localparam int DEPTH  = 8;
   localparam int MARGIN = 2;
   localparam int TDIV   = 3;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      tick = 1'b0;
   logic                      rx = 1'b1;
   logic [1:0]                data_bit_num = 2'b11;
   logic                      stop_bit_num = 1'b0;
   logic                      parity_en = 1'b0;
   logic                      parity_type = 1'b0;
   logic                      rts_n = 1'b0;
   logic                      rd_valid;
   logic                      rd_ready = 1'b0;
   logic [7:0]                rd_data;
   logic                      rd_parity_err;
   logic                      rd_frame_err;
   logic [$clog2(DEPTH):0]    fifo_count;
   logic                      overrun;
   logic                      break_det;
   logic                      cts_n;

   uart_rx_fifo #(
      .OVS        (OVS),
      .FIFO_DEPTH (DEPTH),
      .CTS_MARGIN (MARGIN)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .rx            (rx),
      .data_bit_num  (data_bit_num),
      .stop_bit_num  (stop_bit_num),
      .parity_en     (parity_en),
      .parity_type   (parity_type),
      .rts_n         (rts_n),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .rd_parity_err (rd_parity_err),
      .rd_frame_err  (rd_frame_err),
      .fifo_count    (fifo_count),
      .overrun       (overrun),
      .break_det     (break_det),
      .cts_n         (cts_n)
   );

   always #5 clk = ~clk;

   initial begin
      int tdiv;
      tdiv = 0;
      forever begin
         @(negedge clk);
         tick = (tdiv == TDIV - 1);
         tdiv = (tdiv == TDIV - 1) ? 0 : tdiv + 1;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;
   int ovr_seen = 0;
   int brk_seen = 0;
   int exp_ovr  = 0;
   int exp_brk  = 0;
   logic [9:0] model_q[$];   // {frame_err, parity_err, data}

   always @(posedge clk) begin
      if (overrun)   ovr_seen <= ovr_seen + 1;
      if (break_det) brk_seen <= brk_seen + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      int c;
      c = 0;
      while (c < n) begin
         @(posedge clk);
         if (tick) c++;
      end
   endtask

   task automatic drive_bit(input logic b);
      @(negedge clk);
      rx = b;
      wait_ticks(OVS);
   endtask

   // Sends one frame and predicts its outcome from the frame rules alone.
   task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                             input bit ptype, input bit bad_par, input bit s0,
                             input bit s1, input bit two_stop);
      logic [7:0] mask, masked;
      logic       good_par, pbit, ferr, perr;
      bit         brk;
      @(negedge clk);
      data_bit_num = 2'(nb - 5);
      stop_bit_num = two_stop;
      parity_en    = pen;
      parity_type  = ptype;
      mask     = 8'((1 << nb) - 1);
      masked   = d & mask;
      good_par = (^masked) ^ ptype;
      pbit     = bad_par ? ~good_par : good_par;

      drive_bit(1'b0);
      for (int i = 0; i < nb; i++) drive_bit(d[i]);
      if (pen) drive_bit(pbit);
      drive_bit(s0);
      if (two_stop) drive_bit(s1);
      @(negedge clk);
      rx = 1'b1;
      wait_ticks(4);

      brk = (masked == 8'h00) && (!pen || pbit == 1'b0) && (s0 == 1'b0);
      if (brk) begin
         exp_brk++;
      end else begin
         ferr = !s0 || (two_stop && !s1);
         perr = pen && (pbit != good_par);
         if (model_q.size() == DEPTH) exp_ovr++;
         else model_q.push_back({ferr, perr, masked});
      end
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      chk({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
      chk({tag, "_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
      chk({tag, "_cts"},   32'(cts_n), 32'(rts_n || (model_q.size() >= DEPTH - MARGIN)));
      chk({tag, "_ovr"},   32'(ovr_seen), 32'(exp_ovr));
      chk({tag, "_brk"},   32'(brk_seen), 32'(exp_brk));
      if (model_q.size() != 0)
         chk({tag, "_head"}, 32'({rd_frame_err, rd_parity_err, rd_data}), 32'(model_q[0]));
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (model_q.size() > 0 && guard < DEPTH + 2) begin
         guard++;
         @(negedge clk);
         chk({tag, "_pop_valid"}, 32'(rd_valid), 32'd1);
         chk({tag, "_pop_entry"}, 32'({rd_frame_err, rd_parity_err, rd_data}), 32'(model_q[0]));
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
         void'(model_q.pop_front());
      end
      @(negedge clk);
      chk({tag, "_empty_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_empty_count"}, 32'(fifo_count), 32'd0);
      chk({tag, "_empty_data"},  32'(rd_data), 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      int         nb;
      bit         pen, ptype, bp, s0, s1, ts;

      // Reset state
      repeat (4) @(negedge clk);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_cts",   32'(cts_n), 32'd1);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_data",  32'(rd_data), 32'd0);
      chk("rst_ovr",   32'(overrun), 32'd0);
      chk("rst_brk",   32'(break_det), 32'd0);
      rst_n = 1'b1;
      wait_ticks(2 * OVS);

      // 8N1 0xA5
      send_frame(8'hA5, 8, 0, 0, 0, 1, 1, 0);
      check_state("a5");
      chk("a5_data", 32'(rd_data), 32'hA5);
      drain("a5");

      // 7E2 0x35 with wrong parity bit
      send_frame(8'h35, 7, 1, 0, 1, 1, 1, 1);
      check_state("p7e2");
      chk("p7e2_perr", 32'(rd_parity_err), 32'd1);
      drain("p7e2");

      // 5O1 0x13 with stop bit forced low
      send_frame(8'h13, 5, 1, 1, 0, 0, 0, 0);
      check_state("f5o1");
      chk("f5o1_ferr", 32'(rd_frame_err), 32'd1);
      drain("f5o1");

      // Break: 12 bit-times low, then a normal frame
      @(negedge clk);
      data_bit_num = 2'b11; stop_bit_num = 1'b0; parity_en = 1'b0;
      rx = 1'b0;
      wait_ticks(12 * OVS);
      @(negedge clk);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      exp_brk++;
      check_state("brk");
      send_frame(8'h5A, 8, 0, 0, 0, 1, 1, 0);
      check_state("brk_5a");
      drain("brk_5a");

      // Fill past capacity with reads stalled
      rts_n = 1'b0;
      for (int f = 1; f <= DEPTH + 1; f++) begin
         send_frame(8'($urandom_range(1, 255)), 8, 0, 0, 0, 1, 1, 0);
         check_state($sformatf("fill%0d", f));
      end
      drain("fill");

      // Short glitch must not start a frame
      @(negedge clk);
      rx = 1'b0;
      wait_ticks(3);
      @(negedge clk);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      check_state("glitch");

      // Randomized formats, errors and flow control
      for (int f = 0; f < 20; f++) begin
         d     = 8'($urandom);
         nb    = 5 + $urandom_range(0, 3);
         pen   = 1'($urandom);
         ptype = 1'($urandom);
         bp    = ($urandom_range(0, 3) == 0);
         s0    = ($urandom_range(0, 4) != 0);
         s1    = ($urandom_range(0, 4) != 0);
         ts    = 1'($urandom);
         if ($urandom_range(0, 7) == 0) d = 8'h00;
         @(negedge clk);
         rts_n = ($urandom_range(0, 3) == 0);
         send_frame(d, nb, pen, ptype, bp, s0, s1, ts);
         check_state($sformatf("rnd%0d", f));
         if (model_q.size() >= 4 || $urandom_range(0, 3) == 0) drain($sformatf("rnd%0d", f));
      end
      drain("rnd_end");

      // Reset in the middle of a frame, with an entry already queued
      @(negedge clk);
      rts_n = 1'b0;
      send_frame(8'h3C, 8, 0, 0, 0, 1, 1, 0);
      check_state("pre_rst");
      @(negedge clk);
      data_bit_num = 2'b11; stop_bit_num = 1'b0; parity_en = 1'b0;
      rx = 1'b0;
      wait_ticks(3 * OVS);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 32'(rd_valid), 32'd0);
      chk("midrst_cts",   32'(cts_n), 32'd1);
      chk("midrst_count", 32'(fifo_count), 32'd0);
      rx = 1'b1;
      model_q.delete();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      wait_ticks(2 * OVS);
      check_state("post_rst");
      send_frame(8'hC3, 8, 1, 1, 0, 1, 1, 0);
      check_state("post_rst_frame");
      drain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
